regfile_nway: RTL and testbench
===============================

Name: regfile_nway

Overview:
- Parametrised register file. It is the sequential successor to the fixed 16-bit multi-way mux/demux gate set: width and depth are parameters, entries are clocked storage, and it has two independent read ports.
- One write port with an optional write-to-read bypass.
- A runtime clear sequencer that zeroes every entry, one entry per cycle, with busy/done status.
- Sits between the ALU datapath and instruction decode as the CPU's general register bank.

Parameters:
- WIDTH, 16, bits per entry.
- ADDR_BITS, 3, address width; DEPTH = 2**ADDR_BITS entries (legal 1..8).
- BYPASS, 1, 1 = a same-cycle write to the read address is forwarded to that read port; 0 = the read returns the old stored value.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- we  in  1  write enable.
- waddr  in  ADDR_BITS  write address.
- wdata  in  WIDTH  write data.
- raddr_a  in  ADDR_BITS  read port A address.
- rdata_a  out  WIDTH  read port A data, combinational.
- raddr_b  in  ADDR_BITS  read port B address.
- rdata_b  out  WIDTH  read port B data, combinational.
- clr_req  in  1  request a full clear; sampled only in IDLE.
- busy  out  1  high while the clear sequence runs.
- clr_done  out  1  one-cycle pulse when the clear completes.

Behaviour:
- Reset:
  - Synchronous, active-high; one clock with reset=1 is sufficient.
  - All DEPTH entries become 0, state = IDLE, clear pointer = 0, busy = 0, clr_done = 0.
  - rdata_a and rdata_b read 0 after that edge.
  - Reset overrides we and clr_req in the same cycle.
- States: IDLE, CLEAR.
- IDLE:
  - If we=1, mem[waddr] <= wdata at the edge; visible on both read ports from the next cycle.
  - If clr_req=1, go to CLEAR with ptr <= 0.
  - If we=1 and clr_req=1 in the same cycle, the write is performed, then wiped by the clear.
- CLEAR:
  - Each cycle, mem[ptr] <= 0 and ptr increments.
  - When ptr == DEPTH-1: clear that entry, go to IDLE, and set clr_done for exactly the next cycle.
  - busy=1 in every cycle the state is CLEAR: exactly DEPTH cycles, starting the cycle after clr_req is sampled.
  - clr_done=1 in the first IDLE cycle after CLEAR, with busy=0 in that cycle.
  - we is ignored (the write is dropped) and clr_req is ignored while busy=1.
  - A new clr_req is accepted in the clr_done cycle.
- Read ports:
  - rdata_x = mem[raddr_x], purely combinational with no latency.
  - Both ports may read any address, including the same one, in any state.
  - During CLEAR, reads return current contents: entries below ptr read 0, the rest read old data.
- Bypass (BYPASS=1):
  - When we=1, busy=0 and waddr==raddr_x, rdata_x = wdata in the same cycle.
  - Applies independently per port.
  - With BYPASS=0, rdata_x shows the old value until the edge.
- Pointer: ADDR_BITS wide, wraps naturally; it is never observed outside CLEAR.
- Reset mid-clear: aborts immediately, all entries 0, IDLE, busy=0, no clr_done pulse.
- Widths: no arithmetic on data; entries are stored and returned bit-exact.

Decomposition:
- Shared package holds:
  - state constants ST_IDLE=1'b0 and ST_CLEAR=1'b1;
  - the default WIDTH (16) and ADDR_BITS (3) constants used across the CPU.
- One natural sub-module: mux_nway, a parametrised N-way (2**ADDR_BITS) WIDTH-bit read selector, the generalisation of the fixed 4/8-way 16-bit muxes. It is instantiated once per read port.
- Write decode, bypass and the clear FSM live in regfile_nway.

Test Plan:
- Reset then write: reset 1 cycle, then write 16'h1234 to addr 5 -> rdata_a(raddr_a=5)=16'h0000 before the edge and 16'h1234 after; all other addrs read 0.
- Dual read: write 16'hAAAA@2 and 16'h5555@7, then raddr_a=2, raddr_b=7 -> rdata_a=16'hAAAA, rdata_b=16'h5555 in the same cycle; with raddr_a=raddr_b=7 both read 16'h5555.
- Bypass: BYPASS=1, we=1, waddr=3, wdata=16'hBEEF, raddr_a=3 -> rdata_a=16'hBEEF the same cycle. With BYPASS=0 the same stimulus gives the old value, then 16'hBEEF next cycle.
- Clear sequence: fill all 8 entries with nonzero data, pulse clr_req -> busy=1 for exactly 8 cycles, then clr_done=1 for 1 cycle with busy=0. Mid-sequence reads show the partial clear; all entries read 0 afterwards.
- Clear boundaries:
  - we=1 with clr_req=1 in IDLE -> the entry ends at 0.
  - we=1 while busy -> write dropped; the entry reads 0 after the clear.
  - Second clr_req while busy -> ignored; exactly one clr_done pulse.
- Reset mid-clear: assert reset in the 4th busy cycle -> next cycle busy=0, clr_done=0, all entries 0; a subsequent write of 16'h0F0F@1 works normally.

Source files
------------

// File: rtl/regfile_nway_pkg.sv
// Shared definitions for the general register bank.
//   rf_state_t   : clear sequencer state encoding (ST_IDLE / ST_CLEAR)
//   RF_WIDTH     : default register width used across the CPU
//   RF_ADDR_BITS : default register address width used across the CPU
package regfile_nway_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } rf_state_t;

  localparam int RF_WIDTH     = 16;
  localparam int RF_ADDR_BITS = 3;

endpackage

// File: rtl/regfile_nway_mux_nway.sv
// N-way read selector: returns one WIDTH-bit word out of 2**ADDR_BITS words.
// Ports:
//   din  in  [DEPTH][WIDTH]  all candidate words, index 0 in the low slot
//   sel  in  ADDR_BITS       word select
//   dout out WIDTH           selected word, combinational
module mux_nway
  import regfile_nway_pkg::*;
#(
  parameter int WIDTH     = RF_WIDTH,
  parameter int ADDR_BITS = RF_ADDR_BITS
) (
  input  logic [(1<<ADDR_BITS)-1:0][WIDTH-1:0] din,
  input  logic [ADDR_BITS-1:0]                 sel,
  output logic [WIDTH-1:0]                     dout
);

  assign dout = din[sel];

endmodule

// File: rtl/regfile_nway.sv
// General register bank: one write port, two combinational read ports,
// optional write-to-read forwarding and a one-entry-per-cycle clear sequencer.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   we/waddr/wdata    write port (ignored while the clear runs)
//   raddr_a/rdata_a   read port A, combinational
//   raddr_b/rdata_b   read port B, combinational
//   clr_req           start a full clear (taken only when idle)
//   busy              clear in progress
//   clr_done          one-cycle pulse in the first idle cycle after a clear
module regfile_nway
  import regfile_nway_pkg::*;
#(
  parameter int WIDTH     = RF_WIDTH,
  parameter int ADDR_BITS = RF_ADDR_BITS,
  parameter bit BYPASS    = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [ADDR_BITS-1:0] raddr_a,
  output logic [WIDTH-1:0]     rdata_a,
  input  logic [ADDR_BITS-1:0] raddr_b,
  output logic [WIDTH-1:0]     rdata_b,
  input  logic                 clr_req,
  output logic                 busy,
  output logic                 clr_done
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] PTR_LAST = ADDR_BITS'(DEPTH - 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  rf_state_t                   state, state_nxt;
  logic [ADDR_BITS-1:0]        ptr, ptr_nxt;
  logic                        done_nxt;
  logic                        wr_en;
  logic                        clr_en;
  logic [WIDTH-1:0]            mux_a, mux_b;

  // Control: state, pointer and done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      clr_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    done_nxt  = 1'b0;
    wr_en     = 1'b0;
    clr_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        // A write accompanying clr_req still lands; the clear wipes it later.
        wr_en = we;
        if (clr_req) begin
          state_nxt = ST_CLEAR;
          ptr_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        clr_en  = 1'b1;
        ptr_nxt = ptr + 1'b1;
        if (ptr == PTR_LAST) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign busy = (state == ST_CLEAR);

  // Storage: wr_en and clr_en are never both set
  always_ff @(posedge clk) begin
    if (reset) begin
      mem <= '0;
    end else begin
      if (wr_en)  mem[waddr] <= wdata;
      if (clr_en) mem[ptr]   <= '0;
    end
  end

  // Read selection
  mux_nway #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) u_mux_a (
    .din  (mem),
    .sel  (raddr_a),
    .dout (mux_a)
  );

  mux_nway #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) u_mux_b (
    .din  (mem),
    .sel  (raddr_b),
    .dout (mux_b)
  );

  // Forwarding keys off wr_en so a write dropped during a clear is never seen.
  generate
    if (BYPASS) begin : g_bypass
      assign rdata_a = (wr_en && (waddr == raddr_a)) ? wdata : mux_a;
      assign rdata_b = (wr_en && (waddr == raddr_b)) ? wdata : mux_b;
    end else begin : g_no_bypass
      assign rdata_a = mux_a;
      assign rdata_b = mux_b;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_nway.sv
module tb_regfile_nway;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [2:0]  waddr = '0;
  logic [15:0] wdata = '0;
  logic [2:0]  raddr_a = '0;
  logic [2:0]  raddr_b = '0;
  logic        clr_req = 1'b0;

  logic [15:0] rdata_a, rdata_b;
  logic        busy, clr_done;
  logic [15:0] rdata_a_nb, rdata_b_nb;
  logic        busy_nb, clr_done_nb;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] fillv [8] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                             16'h5555, 16'h6666, 16'h7777, 16'h8888};

  always #20 clk = ~clk;

  regfile_nway #(.WIDTH(16), .ADDR_BITS(3), .BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(raddr_b), .rdata_b(rdata_b),
    .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
  );

  regfile_nway #(.WIDTH(16), .ADDR_BITS(3), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rdata_a_nb), .raddr_b(raddr_b), .rdata_b(rdata_b_nb),
    .clr_req(clr_req), .busy(busy_nb), .clr_done(clr_done_nb)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance past the next rising edge; inputs are changed and outputs
  // sampled well away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [15:0] exp);
    for (int i = 0; i < 8; i++) begin
      raddr_b = 3'(i);
      #1;
      chk($sformatf("%s[%0d]", tag, i), rdata_b, exp);
    end
  endtask

  initial begin
    // Reset
    tick();
    reset = 1'b0;
    #1;
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, clr_done}, 16'd0);
    expect_all("rst_zero", 16'h0000);

    // Reset then write
    we = 1'b1; waddr = 3'd5; wdata = 16'h1234; raddr_a = 3'd5;
    #1;
    chk("wr_pre_nb", rdata_a_nb, 16'h0000);
    chk("wr_pre_byp", rdata_a, 16'h1234);
    tick();
    we = 1'b0;
    #1;
    chk("wr_post", rdata_a, 16'h1234);
    chk("wr_post_nb", rdata_a_nb, 16'h1234);
    for (int i = 0; i < 8; i++) begin
      if (i != 5) begin
        raddr_b = 3'(i);
        #1;
        chk($sformatf("wr_other[%0d]", i), rdata_b, 16'h0000);
      end
    end

    // Dual read
    we = 1'b1; waddr = 3'd2; wdata = 16'hAAAA;
    tick();
    waddr = 3'd7; wdata = 16'h5555;
    tick();
    we = 1'b0; raddr_a = 3'd2; raddr_b = 3'd7;
    #1;
    chk("dual_a", rdata_a, 16'hAAAA);
    chk("dual_b", rdata_b, 16'h5555);
    raddr_a = 3'd7;
    #1;
    chk("same_a", rdata_a, 16'h5555);
    chk("same_b", rdata_b, 16'h5555);

    // Bypass vs no bypass
    we = 1'b1; waddr = 3'd3; wdata = 16'hBEEF; raddr_a = 3'd3; raddr_b = 3'd2;
    #1;
    chk("byp_a", rdata_a, 16'hBEEF);
    chk("byp_other_b", rdata_b, 16'hAAAA);
    chk("nobyp_a_old", rdata_a_nb, 16'h0000);
    tick();
    we = 1'b0;
    #1;
    chk("nobyp_a_new", rdata_a_nb, 16'hBEEF);

    // Fill all entries, then clear
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; waddr = 3'(i); wdata = fillv[i];
      tick();
    end
    we = 1'b0;
    clr_req = 1'b1;
    #1;
    chk("clr_req_busy0", {15'd0, busy}, 16'd0);
    tick();
    clr_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      // k-th busy cycle: entries below k are already cleared
      raddr_b = 3'(k);
      if (k == 3) begin
        we = 1'b1; waddr = 3'd0; wdata = 16'hFFFF; raddr_a = 3'd0;
      end else begin
        we = 1'b0;
        raddr_a = (k > 0) ? 3'(k - 1) : 3'd0;
      end
      clr_req = (k == 4);
      #1;
      chk($sformatf("clr_busy[%0d]", k), {15'd0, busy}, 16'd1);
      chk($sformatf("clr_nodone[%0d]", k), {15'd0, clr_done}, 16'd0);
      chk($sformatf("clr_old[%0d]", k), rdata_b, fillv[k]);
      if (k > 0)
        chk($sformatf("clr_new[%0d]", k), rdata_a, 16'h0000);
      tick();
    end
    we = 1'b0; clr_req = 1'b0;
    #1;
    chk("clr_done_pulse", {15'd0, clr_done}, 16'd1);
    chk("clr_done_busy0", {15'd0, busy}, 16'd0);
    tick();
    chk("clr_done_once", {15'd0, clr_done}, 16'd0);
    chk("clr_idle", {15'd0, busy}, 16'd0);
    expect_all("clr_zero", 16'h0000);

    // Write together with clr_req in IDLE
    we = 1'b1; waddr = 3'd6; wdata = 16'h6666; clr_req = 1'b1;
    tick();
    we = 1'b0; clr_req = 1'b0; raddr_a = 3'd6;
    #1;
    chk("wrclr_busy", {15'd0, busy}, 16'd1);
    chk("wrclr_written", rdata_a, 16'h6666);
    for (int k = 0; k < 7; k++) tick();
    // last busy cycle passed after this tick; now the clr_done cycle
    tick();
    chk("wrclr_done", {15'd0, clr_done}, 16'd1);
    chk("wrclr_wiped", rdata_a, 16'h0000);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("reclr_accepted", {15'd0, busy}, 16'd1);
    // Abort that clear, then set up the reset-mid-clear case
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; waddr = 3'(i); wdata = fillv[i];
      tick();
    end
    we = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick();
    tick();
    tick();
    // 4th busy cycle
    chk("rmc_busy4", {15'd0, busy}, 16'd1);
    raddr_a = 3'd5;
    #1;
    chk("rmc_pre", rdata_a, 16'h6666);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rmc_busy0", {15'd0, busy}, 16'd0);
    chk("rmc_done0", {15'd0, clr_done}, 16'd0);
    expect_all("rmc_zero", 16'h0000);
    tick();
    chk("rmc_done_later", {15'd0, clr_done}, 16'd0);
    we = 1'b1; waddr = 3'd1; wdata = 16'h0F0F;
    tick();
    we = 1'b0; raddr_a = 3'd1;
    #1;
    chk("rmc_write", rdata_a, 16'h0F0F);
    chk("rmc_write_nb", rdata_a_nb, 16'h0F0F);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
